// File: rtl/pcm_sample_fifo_if.sv
// Sample FIFO bus: write strobe/data, read request/data, and status/control.
interface pcm_sample_fifo_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4
);
    logic          en;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          rd_en;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          empty;
    logic          full;
    logic [AW:0]   level;
    logic [AW:0]   thresh;
    logic          irq;
    logic          ovf;
    logic          ovf_clr;

    // Producer/consumer side (FIR + reader)
    modport master (
        output en, in_valid, in_data, rd_en, thresh, ovf_clr,
        input  rd_data, rd_valid, empty, full, level, irq, ovf
    );

    // FIFO side
    modport slave (
        input  en, in_valid, in_data, rd_en, thresh, ovf_clr,
        output rd_data, rd_valid, empty, full, level, irq, ovf
    );
endinterface

// File: rtl/pcm_sample_fifo.sv
// PCM sample FIFO: buffers decimated FIR output for a slower reader.
// Level-tracked occupancy, threshold interrupt and sticky overflow flag.
module pcm_sample_fifo #(
    parameter int unsigned DW = 16,
    parameter int unsigned AW = 4
) (
    input  logic               clk,
    input  logic               rst,
    pcm_sample_fifo_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** AW;
    localparam int unsigned LW    = AW + 1;
    localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_nxt;
    logic [DW-1:0] rd_data_q;
    logic          rd_valid_q;
    logic          empty_q;
    logic          full_q;
    logic          irq_q;
    logic          ovf_q;

    logic          pop;
    logic          wr;
    logic          drop;

    // Handshake decode; full/empty come from the level register so there is no pointer ambiguity
    always_comb begin
        pop  = bus.rd_en && (level_q != '0);
        wr   = bus.in_valid && bus.en && ((level_q != FULL_LVL) || pop);
        drop = bus.in_valid && bus.en && (level_q == FULL_LVL) && !pop;
    end

    // Next occupancy
    always_comb begin
        level_nxt = level_q;
        if (wr && !pop) begin
            level_nxt = level_q + LW'(1);
        end else if (pop && !wr) begin
            level_nxt = level_q - LW'(1);
        end
    end

    // Sample storage; contents survive reset, only the pointers are cleared
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Pointers, level, status flags and read port
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            empty_q    <= 1'b1;
            full_q     <= 1'b0;
            irq_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + AW'(1);
                rd_data_q <= mem[rd_ptr];
            end
            rd_valid_q <= pop;
            level_q    <= level_nxt;
            empty_q    <= (level_nxt == '0);
            full_q     <= (level_nxt == FULL_LVL);
            // Threshold compared against the upcoming level so irq tracks level on the same edge
            irq_q      <= (bus.thresh != '0) && (level_nxt >= bus.thresh);
            // Set wins over clear
            if (drop) begin
                ovf_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_q <= 1'b0;
            end
        end
    end

    // Drive interface outputs from registers
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.empty    = empty_q;
    assign bus.full     = full_q;
    assign bus.level    = level_q;
    assign bus.irq      = irq_q;
    assign bus.ovf      = ovf_q;

endmodule

// File: tb/tb_pcm_sample_fifo.sv
// Directed testbench for pcm_sample_fifo.
module tb_pcm_sample_fifo;
    localparam int unsigned DW = 16;
    localparam int unsigned AW = 4;

    logic clk;
    logic rst;
    int   pass_cnt;
    int   total_cnt;

    pcm_sample_fifo_if #(.DW(DW), .AW(AW)) bus ();

    pcm_sample_fifo #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL reset_empty got %b exp 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.full !== 1'b0) $display("FAIL reset_full got %b exp 0", bus.full); else pass_cnt++;
        total_cnt++; if (bus.level !== 5'd0) $display("FAIL reset_level got %0d exp 0", bus.level); else pass_cnt++;
        total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL reset_rd_valid got %b exp 0", bus.rd_valid); else pass_cnt++;
        total_cnt++; if (bus.irq !== 1'b0) $display("FAIL reset_irq got %b exp 0", bus.irq); else pass_cnt++;
        total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf got %b exp 0", bus.ovf); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h0000) $display("FAIL reset_rd_data got %h exp 0000", bus.rd_data); else pass_cnt++;
        rst = 1'b0;
        step();
    endtask

    task automatic test_order();
        for (int i = 1; i <= 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i);
            step();
            bus.in_valid = 1'b0;
            step();
        end
        total_cnt++; if (bus.level !== 5'd5) $display("FAIL order_level got %0d exp 5", bus.level); else pass_cnt++;
        // rd_en while empty earlier never happened; now read five
        bus.rd_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step();
            total_cnt++; if (bus.rd_valid !== 1'b1) $display("FAIL order_rd_valid[%0d] got %b exp 1", i, bus.rd_valid); else pass_cnt++;
            total_cnt++; if (bus.rd_data !== 16'(i)) $display("FAIL order_rd_data[%0d] got %h exp %h", i, bus.rd_data, 16'(i)); else pass_cnt++;
        end
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL order_empty got %b exp 1", bus.empty); else pass_cnt++;
        // rd_en held while empty: no pop, data holds
        step();
        total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL order_rd_empty_valid got %b exp 0", bus.rd_valid); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h0005) $display("FAIL order_rd_empty_hold got %h exp 0005", bus.rd_data); else pass_cnt++;
        total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL order_rd_empty_ovf got %b exp 0", bus.ovf); else pass_cnt++;
        bus.rd_en = 1'b0;
        step();
    endtask

    task automatic test_overflow();
        // Writes with en=0 are ignored
        bus.en       = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'hDEAD;
        step();
        bus.in_valid = 1'b0;
        bus.en       = 1'b1;
        total_cnt++; if (bus.level !== 5'd0) $display("FAIL en_off_level got %0d exp 0", bus.level); else pass_cnt++;
        total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL en_off_ovf got %b exp 0", bus.ovf); else pass_cnt++;

        for (int i = 0; i < 17; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(16'h0100 + i);
            step();
            if (i == 14) begin
                total_cnt++; if (bus.full !== 1'b0) $display("FAIL ovf_full_at15 got %b exp 0", bus.full); else pass_cnt++;
            end
            if (i == 15) begin
                total_cnt++; if (bus.full !== 1'b1) $display("FAIL ovf_full_at16 got %b exp 1", bus.full); else pass_cnt++;
                total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL ovf_early got %b exp 0", bus.ovf); else pass_cnt++;
            end
            if (i == 16) begin
                total_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf_set got %b exp 1", bus.ovf); else pass_cnt++;
                total_cnt++; if (bus.level !== 5'd16) $display("FAIL ovf_level got %0d exp 16", bus.level); else pass_cnt++;
            end
        end
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b1;
        for (int i = 0; i < 16; i++) begin
            step();
            total_cnt++; if (bus.rd_data !== 16'(16'h0100 + i)) $display("FAIL ovf_drain[%0d] got %h exp %h", i, bus.rd_data, 16'(16'h0100 + i)); else pass_cnt++;
        end
        bus.rd_en = 1'b0;
        step();
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL ovf_empty got %b exp 1", bus.empty); else pass_cnt++;
        total_cnt++; if (bus.ovf !== 1'b1) $display("FAIL ovf_sticky got %b exp 1", bus.ovf); else pass_cnt++;
        bus.ovf_clr = 1'b1;
        step();
        bus.ovf_clr = 1'b0;
        total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL ovf_clr got %b exp 0", bus.ovf); else pass_cnt++;
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(16'h0200 + i);
            step();
        end
        bus.in_data = 16'h02AA;
        bus.rd_en   = 1'b1;
        step();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.level !== 5'd16) $display("FAIL simul_level got %0d exp 16", bus.level); else pass_cnt++;
        total_cnt++; if (bus.ovf !== 1'b0) $display("FAIL simul_ovf got %b exp 0", bus.ovf); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h0200) $display("FAIL simul_oldest got %h exp 0200", bus.rd_data); else pass_cnt++;
        for (int i = 1; i <= 16; i++) begin
            logic [15:0] exp_d;
            exp_d = (i == 16) ? 16'h02AA : 16'(16'h0200 + i);
            step();
            total_cnt++; if (bus.rd_data !== exp_d) $display("FAIL simul_drain[%0d] got %h exp %h", i, bus.rd_data, exp_d); else pass_cnt++;
        end
        bus.rd_en = 1'b0;
        step();
        // Pop + write while empty: write only
        bus.in_valid = 1'b1;
        bus.rd_en    = 1'b1;
        bus.in_data  = 16'h0BEE;
        step();
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.level !== 5'd1) $display("FAIL empty_simul_level got %0d exp 1", bus.level); else pass_cnt++;
        total_cnt++; if (bus.rd_valid !== 1'b0) $display("FAIL empty_simul_rd_valid got %b exp 0", bus.rd_valid); else pass_cnt++;
        step();
        bus.rd_en = 1'b0;
        total_cnt++; if (bus.rd_data !== 16'h0BEE) $display("FAIL empty_simul_pop got %h exp 0bee", bus.rd_data); else pass_cnt++;
        step();
    endtask

    task automatic test_wrap();
        logic [15:0] q [$];
        int          written;
        int          burst;
        int          errs;
        int          max_lvl;
        written = 0;
        burst   = 1;
        errs    = 0;
        max_lvl = 0;
        while (written < 40) begin
            int n;
            n = (40 - written < burst) ? (40 - written) : burst;
            for (int k = 0; k < n; k++) begin
                logic [15:0] d;
                d = 16'(16'hA000 + (written * 16'h0137));
                q.push_back(d);
                bus.in_valid = 1'b1;
                bus.in_data  = d;
                step();
                bus.in_valid = 1'b0;
                written++;
                if (int'(bus.level) > max_lvl) max_lvl = int'(bus.level);
            end
            for (int k = 0; k < n; k++) begin
                logic [15:0] e;
                e = q.pop_front();
                bus.rd_en = 1'b1;
                step();
                bus.rd_en = 1'b0;
                total_cnt++;
                if (bus.rd_valid !== 1'b1 || bus.rd_data !== e) begin
                    $display("FAIL wrap_data[%0d] got %h/%b exp %h/1", written, bus.rd_data, bus.rd_valid, e);
                    errs++;
                end else pass_cnt++;
            end
            burst = (burst == 3) ? 1 : burst + 1;
        end
        total_cnt++; if (bus.empty !== 1'b1) $display("FAIL wrap_empty got %b exp 1", bus.empty); else pass_cnt++;
        total_cnt++; if (max_lvl != 3) $display("FAIL wrap_max_level got %0d exp 3", max_lvl); else pass_cnt++;
        step();
    endtask

    task automatic test_irq();
        bus.thresh = 5'd4;
        for (int i = 1; i <= 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(16'h0300 + i);
            step();
            bus.in_valid = 1'b0;
            total_cnt++; if (bus.irq !== (i == 4)) $display("FAIL irq_fill[%0d] got %b exp %b", i, bus.irq, (i == 4)); else pass_cnt++;
        end
        bus.rd_en = 1'b1;
        step();
        bus.rd_en = 1'b0;
        total_cnt++; if (bus.irq !== 1'b0) $display("FAIL irq_fall got %b exp 0", bus.irq); else pass_cnt++;
        bus.rd_en = 1'b1;
        step(); step(); step();
        bus.rd_en = 1'b0;
        step();
        // thresh 0 disables irq
        bus.thresh = 5'd0;
        for (int i = 1; i <= 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(16'h0400 + i);
            step();
            bus.in_valid = 1'b0;
            total_cnt++; if (bus.irq !== 1'b0) $display("FAIL irq_disabled[%0d] got %b exp 0", i, bus.irq); else pass_cnt++;
        end
        total_cnt++; if (bus.level !== 5'd7) $display("FAIL irq_level7 got %0d exp 7", bus.level); else pass_cnt++;
        bus.thresh = 5'd4;
        step();
        total_cnt++; if (bus.irq !== 1'b1) $display("FAIL irq_reenable got %b exp 1", bus.irq); else pass_cnt++;
        // Reset mid-fill
        rst = 1'b1;
        step();
        rst = 1'b0;
        total_cnt++; if (bus.level !== 5'd0) $display("FAIL rst_mid_level got %0d exp 0", bus.level); else pass_cnt++;
        total_cnt++; if (bus.irq !== 1'b0) $display("FAIL rst_mid_irq got %b exp 0", bus.irq); else pass_cnt++;
        total_cnt++; if (bus.rd_data !== 16'h0000) $display("FAIL rst_mid_rd_data got %h exp 0000", bus.rd_data); else pass_cnt++;
        // First write after reset is the first read back
        bus.in_valid = 1'b1;
        bus.in_data  = 16'h0777;
        step();
        bus.in_valid = 1'b0;
        bus.rd_en    = 1'b1;
        step();
        bus.rd_en = 1'b0;
        total_cnt++; if (bus.rd_data !== 16'h0777) $display("FAIL rst_first_write got %h exp 0777", bus.rd_data); else pass_cnt++;
        // Threshold above depth never fires
        bus.thresh = 5'd17;
        for (int i = 0; i < 16; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 16'(i);
            step();
        end
        bus.in_valid = 1'b0;
        total_cnt++; if (bus.full !== 1'b1) $display("FAIL thresh17_full got %b exp 1", bus.full); else pass_cnt++;
        total_cnt++; if (bus.irq !== 1'b0) $display("FAIL thresh17_irq got %b exp 0", bus.irq); else pass_cnt++;
        bus.thresh = 5'd16;
        step();
        total_cnt++; if (bus.irq !== 1'b1) $display("FAIL thresh16_irq got %b exp 1", bus.irq); else pass_cnt++;
    endtask

    initial begin
        pass_cnt     = 0;
        total_cnt    = 0;
        rst          = 1'b1;
        bus.en       = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.rd_en    = 1'b0;
        bus.thresh   = '0;
        bus.ovf_clr  = 1'b0;

        test_reset();
        test_order();
        test_overflow();
        test_full_simul();
        test_wrap();
        test_irq();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
